chi_aiu_occ_monitor: RTL and testbench

CHI_AIU_OCC_MONITOR -- requirements
Module: chi_aiu_occ_monitor

---
 rtl/chi_aiu_occ_monitor.sv | 185 ++++++++++++++++++
 tb/tb_chi_aiu_occ_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chi_aiu_occ_monitor.sv
// CHI AIU tracker occupancy monitor: OTT/STT occupancy, high-watermarks, per-entry age timeouts.
// Optional QoS starvation tracker is built only when CHI_AIU_OCC_STARV_EN is defined.
module chi_aiu_occ_monitor #(
  parameter int N_OTT = 32,
  parameter int N_STT = 32,
  parameter int AGE_W = 16,
  localparam int OCW  = $clog2(N_OTT + 1),
  localparam int SCW  = $clog2(N_STT + 1),
  localparam int NMAX = (N_OTT > N_STT) ? N_OTT : N_STT,
  localparam int IW   = (NMAX > 1) ? $clog2(NMAX) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_OTT-1:0] ott_entry_validvec,
  input  logic [N_STT-1:0] stt_entry_validvec,
  input  logic             starv_mode,
  input  logic             clear,
  input  logic [AGE_W-1:0] timeout_thresh,
  output logic [OCW-1:0]   ott_count,
  output logic [SCW-1:0]   stt_count,
  output logic [OCW-1:0]   ott_hwm,
  output logic [SCW-1:0]   stt_hwm,
  output logic             ott_full,
  output logic             stt_full,
  output logic             timeout_err,
  output logic             timeout_is_stt,
  output logic [IW-1:0]    timeout_idx,
  output logic [7:0]       timeout_cnt,
  output logic [15:0]      starv_cycles,
  output logic [7:0]       starv_entries,
  output logic             dbg_starv_state
);

  logic [OCW-1:0]   r_ott_count, r_ott_hwm, w_ott_pop;
  logic [SCW-1:0]   r_stt_count, r_stt_hwm, w_stt_pop;
  logic             r_ott_full, r_stt_full;
  logic [AGE_W-1:0] r_ott_age [N_OTT];
  logic [AGE_W-1:0] r_stt_age [N_STT];
  logic [N_OTT-1:0] w_ott_evt;
  logic [N_STT-1:0] w_stt_evt;
  logic [AGE_W-1:0] w_thr_m1;
  logic             w_any_evt, w_cap_stt;
  logic [IW-1:0]    w_cap_idx;
  logic             r_tmo_err, r_tmo_is_stt;
  logic [IW-1:0]    r_tmo_idx;
  logic [7:0]       r_tmo_cnt;

  always_comb begin
    w_ott_pop = '0;
    for (int i = 0; i < N_OTT; i++) w_ott_pop = w_ott_pop + OCW'(ott_entry_validvec[i]);
    w_stt_pop = '0;
    for (int i = 0; i < N_STT; i++) w_stt_pop = w_stt_pop + SCW'(stt_entry_validvec[i]);
  end

  // An entry times out on the single step of its age from thresh-1 to thresh.
  always_comb begin
    w_thr_m1 = timeout_thresh - AGE_W'(1);
    for (int i = 0; i < N_OTT; i++)
      w_ott_evt[i] = (timeout_thresh != '0) && ott_entry_validvec[i] && (r_ott_age[i] == w_thr_m1);
    for (int i = 0; i < N_STT; i++)
      w_stt_evt[i] = (timeout_thresh != '0) && stt_entry_validvec[i] && (r_stt_age[i] == w_thr_m1);
    w_any_evt = (|w_ott_evt) || (|w_stt_evt);
  end

  // Scan high-to-low so the lowest index wins; OTT scanned last so it beats STT.
  always_comb begin
    w_cap_stt = 1'b0;
    w_cap_idx = '0;
    for (int i = N_STT - 1; i >= 0; i--)
      if (w_stt_evt[i]) begin
        w_cap_stt = 1'b1;
        w_cap_idx = IW'(i);
      end
    for (int i = N_OTT - 1; i >= 0; i--)
      if (w_ott_evt[i]) begin
        w_cap_stt = 1'b0;
        w_cap_idx = IW'(i);
      end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_OTT; i++) r_ott_age[i] <= '0;
      for (int i = 0; i < N_STT; i++) r_stt_age[i] <= '0;
    end else begin
      for (int i = 0; i < N_OTT; i++)
        if (!ott_entry_validvec[i])  r_ott_age[i] <= '0;
        else if (r_ott_age[i] != '1) r_ott_age[i] <= r_ott_age[i] + AGE_W'(1);
      for (int i = 0; i < N_STT; i++)
        if (!stt_entry_validvec[i])  r_stt_age[i] <= '0;
        else if (r_stt_age[i] != '1) r_stt_age[i] <= r_stt_age[i] + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ott_count  <= '0;
      r_stt_count  <= '0;
      r_ott_full   <= 1'b0;
      r_stt_full   <= 1'b0;
      r_ott_hwm    <= '0;
      r_stt_hwm    <= '0;
      r_tmo_err    <= 1'b0;
      r_tmo_is_stt <= 1'b0;
      r_tmo_idx    <= '0;
      r_tmo_cnt    <= '0;
    end else begin
      r_ott_count <= w_ott_pop;
      r_stt_count <= w_stt_pop;
      r_ott_full  <= &ott_entry_validvec;
      r_stt_full  <= &stt_entry_validvec;
      if (clear) begin
        r_ott_hwm    <= '0;
        r_stt_hwm    <= '0;
        r_tmo_err    <= 1'b0;
        r_tmo_is_stt <= 1'b0;
        r_tmo_idx    <= '0;
        r_tmo_cnt    <= '0;
      end else begin
        if (w_ott_pop > r_ott_hwm) r_ott_hwm <= w_ott_pop;
        if (w_stt_pop > r_stt_hwm) r_stt_hwm <= w_stt_pop;
        if (w_any_evt && !r_tmo_err) begin
          r_tmo_err    <= 1'b1;
          r_tmo_is_stt <= w_cap_stt;
          r_tmo_idx    <= w_cap_idx;
        end
        if (w_any_evt && (r_tmo_cnt != 8'hFF)) r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end
    end
  end

  assign ott_count      = r_ott_count;
  assign stt_count      = r_stt_count;
  assign ott_hwm        = r_ott_hwm;
  assign stt_hwm        = r_stt_hwm;
  assign ott_full       = r_ott_full;
  assign stt_full       = r_stt_full;
  assign timeout_err    = r_tmo_err;
  assign timeout_is_stt = r_tmo_is_stt;
  assign timeout_idx    = r_tmo_idx;
  assign timeout_cnt    = r_tmo_cnt;

`ifdef CHI_AIU_OCC_STARV_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_STARVED = 1'b1} starv_state_t;

  starv_state_t r_starv_state;
  logic [15:0]  r_starv_cycles;
  logic [7:0]   r_starv_entries;

  // Tracker state is not statistics, so clear only zeroes the counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starv_state   <= ST_IDLE;
      r_starv_cycles  <= '0;
      r_starv_entries <= '0;
    end else begin
      case (r_starv_state)
        ST_IDLE:    if (starv_mode)  r_starv_state <= ST_STARVED;
        ST_STARVED: if (!starv_mode) r_starv_state <= ST_IDLE;
        default:                     r_starv_state <= ST_IDLE;
      endcase
      if (clear) begin
        r_starv_cycles  <= '0;
        r_starv_entries <= '0;
      end else begin
        if ((r_starv_state == ST_IDLE) && starv_mode && (r_starv_entries != 8'hFF))
          r_starv_entries <= r_starv_entries + 8'd1;
        if ((r_starv_state == ST_STARVED) && (r_starv_cycles != 16'hFFFF))
          r_starv_cycles <= r_starv_cycles + 16'd1;
      end
    end
  end

  assign starv_cycles    = r_starv_cycles;
  assign starv_entries   = r_starv_entries;
  assign dbg_starv_state = r_starv_state;
`else
  logic w_unused_starv_mode;
  assign w_unused_starv_mode = starv_mode;
  assign starv_cycles        = '0;
  assign starv_entries       = '0;
  assign dbg_starv_state     = 1'b0;
`endif

endmodule

// File: tb/tb_chi_aiu_occ_monitor.sv
// Testbench for chi_aiu_occ_monitor: occupancy vector table, random scoreboard, timeout/clear/reset/starvation sequences.
module tb_chi_aiu_occ_monitor;

`ifdef CHI_AIU_OCC_STARV_EN
  localparam int STARV_ON = 1;
`else
  localparam int STARV_ON = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [31:0] ott_vec, stt_vec;
  logic        starv_mode, clear;
  logic [15:0] thresh;
  logic [5:0]  ott_count, stt_count, ott_hwm, stt_hwm;
  logic        ott_full, stt_full, timeout_err, timeout_is_stt, dbg_starv_state;
  logic [4:0]  timeout_idx;
  logic [7:0]  timeout_cnt, starv_entries;
  logic [15:0] starv_cycles;

  chi_aiu_occ_monitor dut (
    .clk(clk), .resetn(resetn),
    .ott_entry_validvec(ott_vec), .stt_entry_validvec(stt_vec),
    .starv_mode(starv_mode), .clear(clear), .timeout_thresh(thresh),
    .ott_count(ott_count), .stt_count(stt_count),
    .ott_hwm(ott_hwm), .stt_hwm(stt_hwm),
    .ott_full(ott_full), .stt_full(stt_full),
    .timeout_err(timeout_err), .timeout_is_stt(timeout_is_stt),
    .timeout_idx(timeout_idx), .timeout_cnt(timeout_cnt),
    .starv_cycles(starv_cycles), .starv_entries(starv_entries),
    .dbg_starv_state(dbg_starv_state)
  );

  // scoreboard: packed {ott_count, ott_hwm, ott_full, stt_count, stt_hwm, stt_full}
  logic [25:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] ott;
    logic [31:0] stt;
    logic [5:0]  oc, oh;
    logic        of;
    logic [5:0]  sc, sh;
    logic        sf;
  } vec_t;
  vec_t tbl[6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic clean();
    ott_vec = '0;
    stt_vec = '0;
    clear   = 1'b1;
    tick(1);
    clear   = 1'b0;
  endtask

  function automatic logic [25:0] pack_got();
    return {ott_count, ott_hwm, ott_full, stt_count, stt_hwm, stt_full};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] m_oh, m_sh, m_oc, m_sc;
    logic [31:0] rv_o, rv_s;

    tbl[0] = '{32'h0000_000F, 32'h0000_0000,  6'd4,  6'd4, 1'b0,  6'd0,  6'd0, 1'b0};
    tbl[1] = '{32'h0000_0001, 32'h0000_0000,  6'd1,  6'd4, 1'b0,  6'd0,  6'd0, 1'b0};
    tbl[2] = '{32'h0000_0000, 32'hFFFF_FFFF,  6'd0,  6'd4, 1'b0, 6'd32, 6'd32, 1'b1};
    tbl[3] = '{32'hFFFF_FFFF, 32'h8000_0001, 6'd32, 6'd32, 1'b1,  6'd2, 6'd32, 1'b0};
    tbl[4] = '{32'hAAAA_AAAA, 32'h0000_FFFF, 6'd16, 6'd32, 1'b0, 6'd16, 6'd32, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'h7FFF_FFFF,  6'd1, 6'd32, 1'b0, 6'd31, 6'd32, 1'b0};

    resetn = 1'b0; ott_vec = '0; stt_vec = '0; starv_mode = 1'b0; clear = 1'b0; thresh = '0;
    tick(3);
    check("rst_ott_count", 32'(ott_count), 0);
    check("rst_ott_hwm", 32'(ott_hwm), 0);
    check("rst_stt_full", 32'(stt_full), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_timeout_cnt", 32'(timeout_cnt), 0);
    check("rst_starv_cycles", 32'(starv_cycles), 0);
    resetn = 1'b1;
    tick(1);

    // random occupancy against a popcount/max model
    m_oh = '0; m_sh = '0;
    for (int i = 0; i < 24; i++) begin
      rv_o = $urandom >> $urandom_range(0, 31);
      rv_s = (i == 7) ? 32'hFFFF_FFFF : ($urandom >> $urandom_range(0, 31));
      ott_vec = rv_o;
      stt_vec = rv_s;
      m_oc = 6'($countones(rv_o));
      m_sc = 6'($countones(rv_s));
      if (m_oc > m_oh) m_oh = m_oc;
      if (m_sc > m_sh) m_sh = m_sc;
      exp_q.push_back({m_oc, m_oh, &rv_o, m_sc, m_sh, &rv_s});
      tick(1);
      check($sformatf("rand%0d", i), 32'(pack_got()), 32'(exp_q.pop_front()));
    end

    clean();
    check("clr_ott_hwm", 32'(ott_hwm), 0);
    check("clr_stt_hwm", 32'(stt_hwm), 0);

    for (int i = 0; i < 6; i++) begin
      ott_vec = tbl[i].ott;
      stt_vec = tbl[i].stt;
      exp_q.push_back({tbl[i].oc, tbl[i].oh, tbl[i].of, tbl[i].sc, tbl[i].sh, tbl[i].sf});
      tick(1);
      check($sformatf("tbl%0d", i), 32'(pack_got()), 32'(exp_q.pop_front()));
    end

    // clear drops same-cycle hwm update but not counts
    ott_vec = 32'h3; stt_vec = 32'h7; clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clrw_ott_hwm", 32'(ott_hwm), 0);
    check("clrw_stt_hwm", 32'(stt_hwm), 0);
    check("clrw_ott_count", 32'(ott_count), 2);
    check("clrw_stt_count", 32'(stt_count), 3);
    tick(1);
    check("post_ott_hwm", 32'(ott_hwm), 2);
    check("post_stt_hwm", 32'(stt_hwm), 3);

    // simultaneous OTT/STT timeout: OTT wins
    clean();
    thresh = 16'd10; ott_vec = 32'h1 << 5; stt_vec = 32'h1 << 2;
    tick(9);
    check("a_err_early", 32'(timeout_err), 0);
    tick(1);
    check("a_err", 32'(timeout_err), 1);
    check("a_is_stt", 32'(timeout_is_stt), 0);
    check("a_idx", 32'(timeout_idx), 5);
    check("a_cnt", 32'(timeout_cnt), 1);
    tick(20);
    check("a_cnt_once", 32'(timeout_cnt), 1);

    // STT lowest index, then later OTT event leaves capture alone
    clean();
    thresh = 16'd4; stt_vec = (32'h1 << 7) | (32'h1 << 3);
    tick(4);
    check("b_err", 32'(timeout_err), 1);
    check("b_is_stt", 32'(timeout_is_stt), 1);
    check("b_idx", 32'(timeout_idx), 3);
    ott_vec = 32'h1 << 9;
    tick(4);
    check("b_cnt2", 32'(timeout_cnt), 2);
    check("b_is_stt_kept", 32'(timeout_is_stt), 1);
    check("b_idx_kept", 32'(timeout_idx), 3);

    // deallocation restarts age
    clean();
    thresh = 16'd10; ott_vec = 32'h1 << 3;
    tick(9);
    ott_vec = '0;
    tick(1);
    ott_vec = 32'h1 << 3;
    tick(9);
    check("c_no_err", 32'(timeout_err), 0);
    tick(1);
    check("c_err", 32'(timeout_err), 1);
    check("c_idx", 32'(timeout_idx), 3);

    // threshold 0 disables detection
    clean();
    thresh = '0; ott_vec = '1; stt_vec = '1;
    tick(1000);
    check("d_err", 32'(timeout_err), 0);
    check("d_cnt", 32'(timeout_cnt), 0);

    // clear in the same cycle as a timeout
    clean();
    thresh = 16'd3; ott_vec = 32'h1;
    tick(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("e_err", 32'(timeout_err), 0);
    check("e_cnt", 32'(timeout_cnt), 0);
    tick(5);
    check("e_err_later", 32'(timeout_err), 0);

    // timeout_cnt saturation
    clean();
    thresh = 16'd1;
    repeat (300) begin
      ott_vec = 32'h1;
      tick(1);
      ott_vec = '0;
      tick(1);
    end
    check("f_cnt_sat", 32'(timeout_cnt), 255);
    check("f_idx", 32'(timeout_idx), 0);

    // asynchronous reset mid-run, then age restarts from 0
    thresh = 16'd5; ott_vec = 32'h1 << 1; stt_vec = '1;
    tick(3);
    resetn = 1'b0;
    #2;
    check("g_ott_count", 32'(ott_count), 0);
    check("g_stt_count", 32'(stt_count), 0);
    check("g_stt_full", 32'(stt_full), 0);
    check("g_stt_hwm", 32'(stt_hwm), 0);
    check("g_err", 32'(timeout_err), 0);
    check("g_cnt", 32'(timeout_cnt), 0);
    resetn = 1'b1;
    tick(4);
    check("g_no_err", 32'(timeout_err), 0);
    tick(1);
    check("g_err_after", 32'(timeout_err), 1);
    check("g_is_stt", 32'(timeout_is_stt), 0);
    check("g_idx", 32'(timeout_idx), 1);

    // starvation tracker
    clean();
    thresh = '0;
    for (int e = 0; e < 2; e++) begin
      starv_mode = 1'b1;
      tick(3);
      check($sformatf("h_state%0d", e), 32'(dbg_starv_state), STARV_ON);
      tick(4);
      starv_mode = 1'b0;
      tick(2);
    end
    check("h_entries", 32'(starv_entries), (STARV_ON != 0) ? 2 : 0);
    check("h_cycles", 32'(starv_cycles), (STARV_ON != 0) ? 14 : 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
